// File: rtl/uart_cmd_frame_ctrl.sv
// Turns the UART receiver byte stream into checked fixed-length command frames:
// AA 55 CMD payload[PAY_LEN] CHK, with CHK = 8-bit sum of CMD and payload.
module uart_cmd_frame_ctrl #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned TIMEOUT_US = 2000,
    parameter logic [7:0]  HDR0       = 8'hAA,
    parameter logic [7:0]  HDR1       = 8'h55,
    parameter int unsigned PAY_LEN    = 6
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic [7:0]             rx_data,
    input  logic                   rx_flag,
    output logic [7:0]             cmd,
    output logic [8*PAY_LEN-1:0]   payload,
    output logic                   cmd_valid,
    output logic                   busy,
    output logic                   err_chk,
    output logic                   err_timeout,
    output logic [15:0]            frame_cnt
);

    localparam int unsigned TO_CYC = (CLK_FREQ / 1_000_000) * TIMEOUT_US;
    localparam int unsigned TO_W   = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
    localparam int unsigned IDX_W  = (PAY_LEN > 1) ? $clog2(PAY_LEN) : 1;
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAY_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        CMD,
        PAY,
        CHK
    } state_t;

    state_t                 state;
    logic [7:0]             shadow_cmd;
    logic [8*PAY_LEN-1:0]   shadow_pay;
    logic [IDX_W-1:0]       idx;
    logic [7:0]             sum;
    logic [TO_W-1:0]        to_cnt;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state       <= IDLE;
            shadow_cmd  <= '0;
            shadow_pay  <= '0;
            idx         <= '0;
            sum         <= '0;
            to_cnt      <= '0;
            cmd         <= '0;
            payload     <= '0;
            cmd_valid   <= 1'b0;
            busy        <= 1'b0;
            err_chk     <= 1'b0;
            err_timeout <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            cmd_valid   <= 1'b0;
            err_chk     <= 1'b0;
            err_timeout <= 1'b0;

            if (state == IDLE || rx_flag)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + 1'b1;

            // A strobe landing on the terminal count takes priority over the timeout.
            if (rx_flag) begin
                case (state)
                    IDLE: begin
                        if (rx_data == HDR0) begin
                            state <= SYNC;
                            busy  <= 1'b1;
                        end
                    end
                    SYNC: begin
                        if (rx_data == HDR1) begin
                            state <= CMD;
                        end else if (rx_data != HDR0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    CMD: begin
                        shadow_cmd <= rx_data;
                        sum        <= rx_data;
                        idx        <= '0;
                        state      <= PAY;
                    end
                    PAY: begin
                        shadow_pay[{idx, 3'b000} +: 8] <= rx_data;
                        sum <= sum + rx_data;
                        idx <= idx + 1'b1;
                        if (idx == IDX_LAST)
                            state <= CHK;
                    end
                    CHK: begin
                        if (rx_data == sum) begin
                            cmd       <= shadow_cmd;
                            payload   <= shadow_pay;
                            cmd_valid <= 1'b1;
                            frame_cnt <= frame_cnt + 16'd1;
                        end else begin
                            err_chk <= 1'b1;
                        end
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end else if (state != IDLE && to_cnt == TO_LAST) begin
                state       <= IDLE;
                busy        <= 1'b0;
                err_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: doc/uart_cmd_frame_ctrl.md
Name: uart_cmd_frame_ctrl

Overview:
- Sequences the byte stream from the UART receiver (po_data/po_flag) into fixed-length command frames that configure the IRIG-B encoder, e.g. time set or mode.
- Frame on the wire: 0xAA, 0x55, CMD, 6 payload bytes, CHK, where CHK = 8-bit sum of CMD and the payload bytes.
- Validated frames are presented as one-cycle command strobes; bad frames raise error pulses; stalled frames are abandoned by an inter-byte timeout.

Parameters:
CLK_FREQ  50_000_000  system clock frequency, Hz
TIMEOUT_US  2000  max gap between bytes of one frame, µs
HDR0  8'hAA  first sync byte
HDR1  8'h55  second sync byte
PAY_LEN  6  payload bytes per frame (fixed; range 1..8)

Ports:
sys_clk  input  1  system clock
sys_rst_n  input  1  reset, synchronous, active-low
rx_data  input  8  received byte, valid when rx_flag=1
rx_flag  input  1  one-cycle byte strobe from UART receiver
cmd  output  8  command byte of last good frame
payload  output  8*PAY_LEN  payload of last good frame; first received byte in [7:0]
cmd_valid  output  1  one-cycle pulse: cmd/payload just updated
busy  output  1  high while a frame is in progress (state != IDLE)
err_chk  output  1  one-cycle pulse: checksum mismatch
err_timeout  output  1  one-cycle pulse: frame abandoned on timeout
frame_cnt  output  16  count of good frames

Behaviour:
- Reset: synchronous on sys_clk when sys_rst_n=0. All outputs are 0 (cmd, payload, cmd_valid, busy, err_chk, err_timeout, frame_cnt). State goes to IDLE; shadow buffer, byte index, running sum and timeout counter clear. Reset mid-frame discards the partial frame with no error pulse.
- Timeout constant: TO_CYC = (CLK_FREQ/1_000_000)*TIMEOUT_US. Counter width is derived from it with clog2.
- Bytes are acted on only in cycles with rx_flag=1; rx_data is ignored otherwise.
- FSM states: IDLE, SYNC, CMD, PAY, CHK.
  - IDLE: byte==HDR0 -> SYNC; any other byte -> stay in IDLE.
  - SYNC: byte==HDR1 -> CMD; byte==HDR0 -> stay in SYNC (resync); any other byte -> IDLE, no error.
  - CMD: store byte in the shadow cmd register, sum := byte, idx := 0 -> PAY.
  - PAY: shadow[idx] := byte, sum := sum + byte (mod 256), idx := idx+1. When idx == PAY_LEN-1 on the strobe -> CHK.
  - CHK, byte==sum: copy shadow to cmd/payload, pulse cmd_valid, frame_cnt+1 -> IDLE.
  - CHK, byte!=sum: pulse err_chk, cmd/payload unchanged -> IDLE.
- Latency: cmd/payload/cmd_valid/frame_cnt update at the clock edge ending the cycle in which the CHK-byte rx_flag is high. They are visible in the next cycle, so cmd_valid is high exactly one cycle, coincident with the new data.
- cmd/payload hold their values until the next good frame. Partial or bad frames never disturb them.
- Timeout:
  - Counter clears in IDLE and on every rx_flag.
  - It increments each cycle otherwise.
  - Reaching TO_CYC-1 in a non-IDLE state -> IDLE, one-cycle err_timeout, shadow discarded.
  - If rx_flag coincides with the terminal count, the byte wins: it is processed normally and the counter clears.
- busy = (state != IDLE), registered; it falls in the same cycle cmd_valid/err_chk/err_timeout rise.
- err_chk and err_timeout are mutually exclusive with cmd_valid, and at most one of the three pulses in any cycle.
- frame_cnt wraps 16'hFFFF -> 16'h0000 without an error.
- Header bytes inside CMD/PAY/CHK are ordinary data; no byte stuffing.

Test Plan:
- Good frame AA 55 01 30 45 12 01 02 24 AF (1 µs byte spacing) -> one cmd_valid pulse; cmd=8'h01; payload=48'h240201124530; frame_cnt=1; err_chk=0; err_timeout=0.
- Same frame with CHK=8'hAE -> err_chk pulses once; cmd_valid=0; cmd/payload keep the previous frame (or 0 after reset); frame_cnt unchanged.
- Stream 13 AA AA 55 then 01 30 45 12 01 02 24 AF -> junk is ignored, AA AA resyncs, and the frame is accepted; cmd_valid pulses once.
- AA 55 01 30, then idle for TO_CYC cycles -> err_timeout pulses at cycle TO_CYC-1 after the 0x30 strobe; busy falls. A following good frame is accepted normally.
- Byte strobe placed exactly at the terminal timeout count -> no err_timeout; the frame completes and cmd_valid pulses.
- Reset asserted (sys_rst_n=0, one cycle) after the 4th payload byte -> all outputs 0 next cycle. Remaining bytes are treated as junk in IDLE; no pulses result. Preloading frame_cnt=16'hFFFF via 65535 frames (or force), then one more good frame -> frame_cnt=0.
